// File: rtl/pc_sequencer_pkg.sv
// Shared branch encodings and next-PC select type for the PC sequencer.
package pc_sequencer_pkg;

    // Conditional branch funct3 encodings
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Source of the next fetch PC
    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_TRAP,
        SEL_REDIR,
        SEL_HOLD,
        SEL_SEQ
    } next_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch handshake plus branch/jump/trap resolution bundle around the PC sequencer.
// master: the sequencer itself; slave: imem + control/execute side.
interface pc_sequencer_if #(
    parameter int unsigned XLEN = 64
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            stall;
    logic [XLEN-1:0] res_pc;
    logic            br_valid;
    logic [2:0]      br_funct3;
    logic            cmp_zero;
    logic            cmp_lt;
    logic            cmp_ltu;
    logic            jmp_valid;
    logic            jmp_reg;
    logic [XLEN-1:0] jmp_base;
    logic [XLEN-1:0] imm;
    logic            trap_valid;
    logic [XLEN-1:0] trap_target;
    logic            flush;
    logic            br_taken;
    logic            misalign_exc;
    logic [XLEN-1:0] misalign_addr;

    modport master (
        output fetch_valid, pc, pc_plus4, flush, br_taken, misalign_exc, misalign_addr,
        input  fetch_ready, stall, res_pc, br_valid, br_funct3, cmp_zero, cmp_lt, cmp_ltu,
        input  jmp_valid, jmp_reg, jmp_base, imm, trap_valid, trap_target
    );

    modport slave (
        input  fetch_valid, pc, pc_plus4, flush, br_taken, misalign_exc, misalign_addr,
        output fetch_ready, stall, res_pc, br_valid, br_funct3, cmp_zero, cmp_lt, cmp_ltu,
        output jmp_valid, jmp_reg, jmp_base, imm, trap_valid, trap_target
    );

endinterface

// File: rtl/pc_sequencer_branch_cond.sv
// Branch condition decode: funct3 plus comparator flags -> taken.
module pc_sequencer_branch_cond
    import pc_sequencer_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       cmp_zero_i,
    input  logic       cmp_lt_i,
    input  logic       cmp_ltu_i,
    output logic       taken_o
);

    // Reserved encodings 010/011 never take
    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            BR_BEQ:  taken_o = cmp_zero_i;
            BR_BNE:  taken_o = ~cmp_zero_i;
            BR_BLT:  taken_o = cmp_lt_i;
            BR_BGE:  taken_o = ~cmp_lt_i;
            BR_BLTU: taken_o = cmp_ltu_i;
            BR_BGEU: taken_o = ~cmp_ltu_i;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential fetch, stall, branch/jump/trap redirect with flush pulse,
// and misaligned-target detection.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     IALIGN       = 4
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
);

    localparam logic [XLEN-1:0] AlignMask = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] Four      = XLEN'(4);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            fv_q, fv_d;
    logic            flush_q, flush_d;
    logic            mexc_q, mexc_d;
    logic [XLEN-1:0] maddr_q, maddr_d;

    logic            cond_taken;
    logic            redir;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] target;
    logic            misaligned;
    logic [XLEN-1:0] pc_inc;
    next_sel_e       sel;

    pc_sequencer_branch_cond u_branch_cond (
        .funct3_i   (bus.br_funct3),
        .cmp_zero_i (bus.cmp_zero),
        .cmp_lt_i   (bus.cmp_lt),
        .cmp_ltu_i  (bus.cmp_ltu),
        .taken_o    (cond_taken)
    );

    // Single target adder shared by branch, JAL and JALR; jumps win over branches
    always_comb begin
        redir      = bus.jmp_valid | (bus.br_valid & cond_taken);
        base       = (bus.jmp_valid && bus.jmp_reg) ? bus.jmp_base : bus.res_pc;
        sum        = base + bus.imm;
        target     = (bus.jmp_valid && bus.jmp_reg) ? {sum[XLEN-1:1], 1'b0} : sum;
        misaligned = |(target & AlignMask);
        pc_inc     = pc_q + Four;
    end

    // Next-PC source in priority order
    always_comb begin
        sel = SEL_HOLD;
        if (rst) begin
            sel = SEL_RESET;
        end else if (bus.trap_valid) begin
            sel = SEL_TRAP;
        end else if (redir && !misaligned) begin
            sel = SEL_REDIR;
        end else if (redir) begin
            sel = SEL_HOLD;
        end else if (bus.stall || !fv_q || !bus.fetch_ready) begin
            sel = SEL_HOLD;
        end else begin
            sel = SEL_SEQ;
        end
    end

    // Next-state for PC, valid and the pulse/capture registers
    always_comb begin
        pc_d    = pc_q;
        fv_d    = 1'b1;
        flush_d = 1'b0;
        mexc_d  = 1'b0;
        maddr_d = maddr_q;
        unique case (sel)
            SEL_RESET: begin
                pc_d    = RESET_VECTOR;
                fv_d    = 1'b0;
                maddr_d = '0;
            end
            SEL_TRAP: begin
                pc_d    = bus.trap_target;
                flush_d = 1'b1;
            end
            SEL_REDIR: begin
                pc_d    = target;
                flush_d = 1'b1;
            end
            SEL_HOLD: begin
                // A redirect landing here is a misaligned target: report it, keep the PC
                if (redir) begin
                    mexc_d  = 1'b1;
                    maddr_d = target;
                end
            end
            SEL_SEQ: begin
                pc_d = pc_inc;
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            fv_q    <= 1'b0;
            flush_q <= 1'b0;
            mexc_q  <= 1'b0;
            maddr_q <= '0;
        end else begin
            pc_q    <= pc_d;
            fv_q    <= fv_d;
            flush_q <= flush_d;
            mexc_q  <= mexc_d;
            maddr_q <= maddr_d;
        end
    end

    assign bus.fetch_valid   = fv_q;
    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = pc_inc;
    assign bus.flush         = flush_q;
    assign bus.br_taken      = redir;
    assign bus.misalign_exc  = mexc_q;
    assign bus.misalign_addr = maddr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps then randomized traffic against a
// behavioural reference model built from register operand values.
module tb_pc_sequencer;

    localparam int unsigned XLEN = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    logic [63:0] m_pc    = 64'h0;
    logic        m_fv    = 1'b0;
    logic        m_flush = 1'b0;
    logic        m_mexc  = 1'b0;
    logic [63:0] m_maddr = 64'h0;
    logic [63:0] m_rs1   = 64'h0;
    logic [63:0] m_rs2   = 64'h0;

    pc_sequencer_if #(.XLEN(XLEN)) bus ();

    pc_sequencer #(
        .XLEN         (XLEN),
        .RESET_VECTOR (64'h0),
        .IALIGN       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Branch outcome from the operand values themselves
    function automatic logic ref_taken(input logic [2:0] f3, input logic [63:0] a,
                                       input logic [63:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_ops(input logic [63:0] a, input logic [63:0] b);
        m_rs1        = a;
        m_rs2        = b;
        bus.cmp_zero = (a == b);
        bus.cmp_lt   = ($signed(a) < $signed(b));
        bus.cmp_ltu  = (a < b);
    endtask

    task automatic clr();
        bus.stall       = 1'b0;
        bus.res_pc      = 64'h0;
        bus.br_valid    = 1'b0;
        bus.br_funct3   = 3'd0;
        bus.jmp_valid   = 1'b0;
        bus.jmp_reg     = 1'b0;
        bus.jmp_base    = 64'h0;
        bus.imm         = 64'h0;
        bus.trap_valid  = 1'b0;
        bus.trap_target = 64'h0;
        set_ops(64'h0, 64'h1);
    endtask

    // One clock: check br_taken, advance model, then compare registered outputs
    task automatic tick();
        logic        taken;
        logic [63:0] tgt;
        logic [63:0] n_pc;
        logic        n_fv, n_flush, n_mexc;
        logic [63:0] n_maddr;
        #1;
        taken = bus.jmp_valid || (bus.br_valid && ref_taken(bus.br_funct3, m_rs1, m_rs2));
        if (bus.jmp_valid && bus.jmp_reg)
            tgt = (bus.jmp_base + bus.imm) & ~64'd1;
        else
            tgt = bus.res_pc + bus.imm;
        if (!rst && !bus.trap_valid && (!taken || (tgt % 4 == 0)))
            chk("br_taken", {63'b0, bus.br_taken}, {63'b0, taken});
        n_pc = m_pc; n_fv = 1'b1; n_flush = 1'b0; n_mexc = 1'b0; n_maddr = m_maddr;
        if (rst) begin
            n_pc = 64'h0; n_fv = 1'b0; n_maddr = 64'h0;
        end else if (bus.trap_valid) begin
            n_pc = bus.trap_target; n_flush = 1'b1;
        end else if (taken) begin
            if (tgt % 4 != 0) begin
                n_mexc = 1'b1; n_maddr = tgt;
            end else begin
                n_pc = tgt; n_flush = 1'b1;
            end
        end else if (!bus.stall && m_fv && bus.fetch_ready) begin
            n_pc = m_pc + 64'd4;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_fv = n_fv; m_flush = n_flush; m_mexc = n_mexc; m_maddr = n_maddr;
        chk("pc", bus.pc, m_pc);
        chk("pc_plus4", bus.pc_plus4, m_pc + 64'd4);
        chk("fetch_valid", {63'b0, bus.fetch_valid}, {63'b0, m_fv});
        chk("flush", {63'b0, bus.flush}, {63'b0, m_flush});
        chk("misalign_exc", {63'b0, bus.misalign_exc}, {63'b0, m_mexc});
        chk("misalign_addr", bus.misalign_addr, m_maddr);
    endtask

    initial begin
        logic [63:0] r;
        clr();
        bus.fetch_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_pc", bus.pc, 64'h0);
        chk("rst_fv", {63'b0, bus.fetch_valid}, 64'h0);

        // Release, then sequential fetch
        rst = 1'b0;
        bus.fetch_ready = 1'b1;
        tick();
        chk("fv_after_rst", {63'b0, bus.fetch_valid}, 64'h1);
        chk("seq0", bus.pc, 64'h0);
        tick(); chk("seq4", bus.pc, 64'h4);
        tick(); chk("seq8", bus.pc, 64'h8);
        tick(); chk("seq12", bus.pc, 64'hC);

        // BNE taken, negative offset
        bus.br_valid = 1'b1; bus.br_funct3 = 3'b001; bus.res_pc = 64'h100;
        bus.imm = -64'sd8; set_ops(64'h5, 64'h6);
        tick();
        chk("bne_pc", bus.pc, 64'hF8);
        chk("bne_flush", {63'b0, bus.flush}, 64'h1);
        clr();
        tick();
        chk("bne_flush_end", {63'b0, bus.flush}, 64'h0);

        // JALR to a halfword-aligned target: misaligned with IALIGN=4
        r = bus.pc;
        bus.jmp_valid = 1'b1; bus.jmp_reg = 1'b1; bus.jmp_base = 64'h201; bus.imm = 64'h2;
        bus.fetch_ready = 1'b0;
        tick();
        chk("jalr_mexc", {63'b0, bus.misalign_exc}, 64'h1);
        chk("jalr_maddr", bus.misalign_addr, 64'h202);
        chk("jalr_pc_held", bus.pc, r);
        chk("jalr_noflush", {63'b0, bus.flush}, 64'h0);
        clr();
        tick();
        chk("maddr_held", bus.misalign_addr, 64'h202);

        // Trap beats a taken branch and a stall
        bus.fetch_ready = 1'b1;
        bus.trap_valid = 1'b1; bus.trap_target = 64'h8000_0000;
        bus.br_valid = 1'b1; bus.br_funct3 = 3'b000; set_ops(64'h7, 64'h7);
        bus.res_pc = 64'h40; bus.imm = 64'h10; bus.stall = 1'b1;
        tick();
        chk("trap_pc", bus.pc, 64'h8000_0000);
        clr();
        tick();
        chk("trap_flush_end", {63'b0, bus.flush}, 64'h0);

        // Stall then fetch_ready low: PC holds
        r = bus.pc;
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("stall_hold", bus.pc, r);
        bus.stall = 1'b0; bus.fetch_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("notready_hold", bus.pc, r);

        // Reserved funct3 never taken, whatever the flags
        bus.fetch_ready = 1'b1; bus.br_valid = 1'b1; bus.imm = 64'h40;
        for (int f = 2; f < 4; f++) begin
            for (int k = 0; k < 8; k++) begin
                r = bus.pc;
                bus.br_funct3 = 3'(f);
                bus.cmp_zero = k[0]; bus.cmp_lt = k[1]; bus.cmp_ltu = k[2];
                tick();
                chk("reserved_f3", bus.pc, r + 64'd4);
            end
        end
        clr();

        // Wrap at the top of the address space
        bus.jmp_valid = 1'b1; bus.jmp_reg = 1'b0; bus.res_pc = 64'h0; bus.imm = -64'sd4;
        tick();
        chk("top_pc", bus.pc, 64'hFFFF_FFFF_FFFF_FFFC);
        clr();
        tick();
        chk("wrap_pc", bus.pc, 64'h0);

        // Reset during a redirect
        bus.jmp_valid = 1'b1; bus.res_pc = 64'h300; bus.imm = 64'h20;
        rst = 1'b1;
        tick();
        chk("rst_redir_pc", bus.pc, 64'h0);
        chk("rst_redir_flush", {63'b0, bus.flush}, 64'h0);
        rst = 1'b0;
        clr();
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(0, 49) == 0);
            bus.fetch_ready = ($urandom_range(0, 3) != 0);
            bus.stall       = ($urandom_range(0, 3) == 0);
            bus.trap_valid  = ($urandom_range(0, 15) == 0);
            bus.trap_target = {$urandom, $urandom} & ~64'd3;
            bus.br_valid    = ($urandom_range(0, 2) == 0);
            bus.br_funct3   = 3'($urandom_range(0, 7));
            bus.jmp_valid   = ($urandom_range(0, 4) == 0);
            bus.jmp_reg     = $urandom_range(0, 1) == 1;
            bus.jmp_base    = {$urandom, $urandom};
            bus.res_pc      = ($urandom_range(0, 1) == 1) ? m_pc : ({$urandom, $urandom} & ~64'd3);
            r = 64'($urandom);
            bus.imm = {{52{r[11]}}, r[11:0]};
            if ($urandom_range(0, 1) == 1) bus.imm[1:0] = 2'b00;
            r = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       set_ops(r, r);
                1:       set_ops(r, {$urandom, $urandom});
                default: set_ops(r, ~r);
            endcase
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
